lc3_controller: RTL and testbench

- Multi-cycle sequencer for the LC-3 datapath; emits the 4-bit `state` consumed by the decode, execute, memaccess, writeback and fetch blocks.
- Classifies each instruction from the decoder's C_Control/F_Control/M_Control lines and walks it through fetch, decode, execute, memory (direct or indirect) and writeback/PC-update phases.
- Owns the memory request handshake, the retired-instruction counter and the sticky bad-opcode halt.

---
 rtl/lc3_ctrl_pkg.sv | 33 +++
 rtl/lc3_mem_wait.sv | 37 +++
 rtl/lc3_controller.sv | 171 +++++++++++++++++
 tb/tb_lc3_controller.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_ctrl_pkg.sv
// rtl/lc3_ctrl_pkg.sv - state codes, instruction classes and detail codes for the LC-3 sequencer
package lc3_ctrl_pkg;

  localparam logic [3:0] ST_RESET      = 4'b0000;
  localparam logic [3:0] ST_FETCH      = 4'b0001;
  localparam logic [3:0] ST_DECODE     = 4'b0010;
  localparam logic [3:0] ST_EXECUTE    = 4'b0011;
  localparam logic [3:0] ST_READ_MEM   = 4'b0100;
  localparam logic [3:0] ST_READ_IND   = 4'b0101;
  localparam logic [3:0] ST_WRITE_MEM  = 4'b0110;
  localparam logic [3:0] ST_UPDATE_PC  = 4'b1000;
  localparam logic [3:0] ST_UPDATE_REG = 4'b1001;
  localparam logic [3:0] ST_ERROR      = 4'b1111;

  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_GOTO  = 2'b01;
  localparam logic [1:0] CLS_LDST  = 2'b10;
  localparam logic [1:0] CLS_BAD   = 2'b11;

  localparam logic [3:0] DET_LEA = 4'b0110;
  localparam logic [3:0] DET_LD  = 4'b0010;
  localparam logic [3:0] DET_LDI = 4'b0001;
  localparam logic [3:0] DET_ST  = 4'b0100;
  localparam logic [3:0] DET_STI = 4'b0000;
  localparam logic [3:0] DET_JSR = 4'b1000;

  // States that hold mem_en and wait for the mem_rdy pulse.
  function automatic logic is_mem_state(input logic [3:0] s);
    return (s == ST_FETCH) || (s == ST_READ_IND) ||
           (s == ST_READ_MEM) || (s == ST_WRITE_MEM);
  endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// rtl/lc3_mem_wait.sv - mem_rdy wait counter raising timeout_o when a memory wait runs too long
module lc3_mem_wait #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic waiting_i,
  input  logic mem_rdy_i,
  output logic timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (waiting_i && !mem_rdy_i && (cnt_q != CW'(TIMEOUT_CYCLES))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the cycle whose closing edge would bring the count to the limit.
  assign timeout_o = waiting_i && !mem_rdy_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lc3_controller.sv
// rtl/lc3_controller.sv - LC-3 multi-cycle sequencer; optional mem_rdy timeout under LC3_MEM_TIMEOUT_EN
module lc3_controller
  import lc3_ctrl_pkg::*;
#(
  parameter int COUNT_W = 16
`ifdef LC3_MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         c_control,
  input  logic               f_control,
  input  logic               m_control,
  input  logic               mem_rdy,
  output logic [3:0]         state,
  output logic               mem_en,
  output logic               mem_we,
  output logic               ind_sel,
  output logic               pc_inc,
  output logic               pc_load,
  output logic               rf_we,
  output logic               halted,
  output logic [COUNT_W-1:0] instr_count
);

  logic [3:0]         state_q, state_d;
  logic [1:0]         cls_q, cls_d;
  logic               is_jsr_q, is_jsr_d;
  logic               is_sti_q, is_sti_d;
  logic               via_ind_q, via_ind_d;
  logic               pc_inc_q, pc_inc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               retire;

`ifdef LC3_MEM_TIMEOUT_EN
  logic timeout;

  lc3_mem_wait #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mem_wait (
    .clk_i    (clock),
    .rst_ni   (reset),
    .clear_i  (state_d != state_q),
    .waiting_i(is_mem_state(state_q)),
    .mem_rdy_i(mem_rdy),
    .timeout_o(timeout)
  );
`endif

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    is_jsr_d  = is_jsr_q;
    is_sti_d  = is_sti_q;
    via_ind_d = via_ind_q;

    case (state_q)
      ST_RESET: state_d = ST_FETCH;

      ST_FETCH: if (mem_rdy) state_d = ST_DECODE;

      ST_DECODE: begin
        cls_d   = c_control[5:4];
        state_d = (c_control[5:4] == CLS_BAD) ? ST_ERROR : ST_EXECUTE;
      end

      ST_EXECUTE: begin
        case (cls_q)
          CLS_ARITH: state_d = ST_UPDATE_REG;
          CLS_GOTO: begin
            if ((c_control[3:0] & DET_JSR) != 4'b0000) begin
              is_jsr_d = 1'b1;
              state_d  = ST_UPDATE_REG;
            end else if (f_control) begin
              state_d = ST_UPDATE_PC;
            end else begin
              state_d = ST_FETCH;
            end
          end
          CLS_LDST: begin
            case (c_control[3:0])
              DET_LEA: state_d = ST_UPDATE_REG;
              DET_LD:  state_d = ST_READ_MEM;
              DET_LDI: state_d = ST_READ_IND;
              DET_ST:  state_d = ST_WRITE_MEM;
              DET_STI: begin
                if (m_control) begin
                  is_sti_d = 1'b1;
                  state_d  = ST_READ_IND;
                end else begin
                  state_d = ST_ERROR;
                end
              end
              default: state_d = ST_ERROR;
            endcase
          end
          default: state_d = ST_ERROR;
        endcase
      end

      ST_READ_IND: begin
        if (mem_rdy) begin
          via_ind_d = 1'b1;
          state_d   = is_sti_q ? ST_WRITE_MEM : ST_READ_MEM;
        end
      end

      ST_READ_MEM:   if (mem_rdy) state_d = ST_UPDATE_REG;
      ST_WRITE_MEM:  if (mem_rdy) state_d = ST_FETCH;
      ST_UPDATE_REG: state_d = is_jsr_q ? ST_UPDATE_PC : ST_FETCH;
      ST_UPDATE_PC:  state_d = ST_FETCH;
      ST_ERROR:      state_d = ST_ERROR;
      default:       state_d = ST_ERROR;
    endcase

`ifdef LC3_MEM_TIMEOUT_EN
    if (timeout) state_d = ST_ERROR;
`endif

    // RESET -> FETCH is deliberately excluded: only completed instructions retire.
    retire = (state_d == ST_FETCH) &&
             ((state_q == ST_EXECUTE) || (state_q == ST_WRITE_MEM) ||
              (state_q == ST_UPDATE_REG) || (state_q == ST_UPDATE_PC));

    count_d = retire ? count_q + COUNT_W'(1) : count_q;
    if (retire) begin
      is_jsr_d  = 1'b0;
      is_sti_d  = 1'b0;
      via_ind_d = 1'b0;
    end

    pc_inc_d = (state_q == ST_FETCH) && mem_rdy;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_RESET;
      cls_q     <= CLS_ARITH;
      is_jsr_q  <= 1'b0;
      is_sti_q  <= 1'b0;
      via_ind_q <= 1'b0;
      pc_inc_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      is_jsr_q  <= is_jsr_d;
      is_sti_q  <= is_sti_d;
      via_ind_q <= via_ind_d;
      pc_inc_q  <= pc_inc_d;
      count_q   <= count_d;
    end
  end

  // Strobes are decoded from registered state only, so reset drops them asynchronously.
  always_comb begin
    mem_en  = is_mem_state(state_q);
    mem_we  = (state_q == ST_WRITE_MEM);
    ind_sel = ((state_q == ST_READ_MEM) && via_ind_q) ||
              ((state_q == ST_WRITE_MEM) && is_sti_q);
    rf_we   = (state_q == ST_UPDATE_REG);
    pc_load = (state_q == ST_UPDATE_PC);
    halted  = (state_q == ST_ERROR);
  end

  assign state       = state_q;
  assign pc_inc      = pc_inc_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_lc3_controller.sv
// tb/tb_lc3_controller.sv - randomized self-checking bench for lc3_controller against a path-level model
module tb_lc3_controller;

  localparam logic [3:0] S_RESET = 4'b0000;
  localparam logic [3:0] S_FETCH = 4'b0001;
  localparam logic [3:0] S_DEC   = 4'b0010;
  localparam logic [3:0] S_EXEC  = 4'b0011;
  localparam logic [3:0] S_RMEM  = 4'b0100;
  localparam logic [3:0] S_RIND  = 4'b0101;
  localparam logic [3:0] S_WMEM  = 4'b0110;
  localparam logic [3:0] S_UPC   = 4'b1000;
  localparam logic [3:0] S_UREG  = 4'b1001;
  localparam logic [3:0] S_ERR   = 4'b1111;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  c_control;
  logic        f_control, m_control, mem_rdy;
  logic [3:0]  state;
  logic        mem_en, mem_we, ind_sel, pc_inc, pc_load, rf_we, halted;
  logic [15:0] instr_count;

  int compared    = 0;
  int mismatched  = 0;
  int model_count = 0;

  always #5 clock = ~clock;

  lc3_controller #(.COUNT_W(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .c_control  (c_control),
    .f_control  (f_control),
    .m_control  (m_control),
    .mem_rdy    (mem_rdy),
    .state      (state),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .ind_sel    (ind_sel),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .rf_we      (rf_we),
    .halted     (halted),
    .instr_count(instr_count)
  );

  function automatic bit is_mem(input logic [3:0] s);
    return (s == S_FETCH) || (s == S_RIND) || (s == S_RMEM) || (s == S_WMEM);
  endfunction

  // Called at a falling edge; leaves the bench at a falling edge with the DUT in FETCH.
  task automatic do_reset();
    reset = 1'b0;
    mem_rdy = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    model_count = 0;
  endtask

  // Runs one instruction from FETCH; the expected path is derived from the instruction rules.
  task automatic run_instr(input logic [1:0] cls, input logic [3:0] det, input logic f,
                           input logic m, input int dly, output bit errored);
    logic [3:0] path[$];
    bit         sti, via_ind;
    int         pcinc_seen, nwait;
    logic [5:0] exp_o, got_o;
    logic [15:0] cnt_at_err;
    errored    = 1'b0;
    pcinc_seen = 0;
    via_ind    = 1'b0;
    sti        = (cls == 2'b10) && (det == 4'b0000) && m;
    path       = '{S_FETCH, S_DEC};
    if (cls == 2'b11) begin
      path.push_back(S_ERR);
    end else begin
      path.push_back(S_EXEC);
      case (cls)
        2'b00: path.push_back(S_UREG);
        2'b01: begin
          if (det[3]) begin path.push_back(S_UREG); path.push_back(S_UPC); end
          else if (f) path.push_back(S_UPC);
        end
        default: begin
          case (det)
            4'b0110: path.push_back(S_UREG);
            4'b0010: begin path.push_back(S_RMEM); path.push_back(S_UREG); end
            4'b0001: begin path.push_back(S_RIND); path.push_back(S_RMEM); path.push_back(S_UREG); end
            4'b0100: path.push_back(S_WMEM);
            4'b0000: begin
              if (m) begin path.push_back(S_RIND); path.push_back(S_WMEM); end
              else path.push_back(S_ERR);
            end
            default: path.push_back(S_ERR);
          endcase
        end
      endcase
    end
    foreach (path[k]) if (path[k] == S_RIND) via_ind = 1'b1;

    c_control = {cls, det};
    f_control = f;
    m_control = m;

    foreach (path[k]) begin
      if (path[k] == S_ERR) begin
        errored = 1'b1;
        cnt_at_err = instr_count;
        compared++;
        if (state !== S_ERR || halted !== 1'b1) begin
          mismatched++;
          $display("FAIL error_entry cls=%b det=%b: state=%b halted=%b, required state=1111 halted=1",
                   cls, det, state, halted);
        end
        for (int h = 0; h < 4; h++) begin
          mem_rdy = 1'($urandom_range(0, 1));
          @(negedge clock);
          got_o = {mem_en, mem_we, ind_sel, rf_we, pc_load, halted};
          compared++;
          if (state !== S_ERR || got_o !== 6'b000001 || pc_inc !== 1'b0 || instr_count !== cnt_at_err) begin
            mismatched++;
            $display("FAIL error_sticky: state=%b strobes=%b pc_inc=%b count=%0d, required 1111/000001/0/%0d",
                     state, got_o, pc_inc, instr_count, cnt_at_err);
          end
        end
      end else begin
        nwait = is_mem(path[k]) ? ((dly >= 0) ? dly : int'($urandom_range(0, 3))) : 0;
        for (int w = 0; w <= nwait; w++) begin
          compared++;
          if (state !== path[k]) begin
            mismatched++;
            $display("FAIL state cls=%b det=%b step=%0d: got %b, required %b", cls, det, k, state, path[k]);
          end
          exp_o = {is_mem(path[k]), path[k] == S_WMEM,
                   ((path[k] == S_RMEM) && via_ind) || ((path[k] == S_WMEM) && sti),
                   path[k] == S_UREG, path[k] == S_UPC, 1'b0};
          got_o = {mem_en, mem_we, ind_sel, rf_we, pc_load, halted};
          compared++;
          if (got_o !== exp_o) begin
            mismatched++;
            $display("FAIL strobes cls=%b det=%b state=%b: got %b, required %b (en,we,ind,rf,pcl,halt)",
                     cls, det, path[k], got_o, exp_o);
          end
          if (pc_inc === 1'b1) pcinc_seen++;
          mem_rdy = is_mem(path[k]) ? (w == nwait) : 1'($urandom_range(0, 1));
          @(negedge clock);
        end
      end
    end
    mem_rdy = 1'b0;

    compared++;
    if (pcinc_seen != 1) begin
      mismatched++;
      $display("FAIL pc_inc_pulses cls=%b det=%b: got %0d, required 1", cls, det, pcinc_seen);
    end
    if (!errored) begin
      model_count++;
      compared++;
      if (state !== S_FETCH || instr_count !== 16'(model_count)) begin
        mismatched++;
        $display("FAIL retire cls=%b det=%b: state=%b count=%0d, required 0001 count=%0d",
                 cls, det, state, instr_count, 16'(model_count));
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    c_control = 6'b0;
    f_control = 1'b0;
    m_control = 1'b0;
    mem_rdy   = 1'b0;
    #1;
    compared++;
    if ({state, mem_en, mem_we, ind_sel, pc_inc, pc_load, rf_we, halted} !== 11'b0 || instr_count !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_values: state=%b strobes=%b%b%b%b%b%b%b count=%0d, required all zero",
               state, mem_en, mem_we, ind_sel, pc_inc, pc_load, rf_we, halted, instr_count);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    compared++;
    if (state !== S_FETCH || instr_count !== 16'd0 || mem_en !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_to_fetch: state=%b count=%0d mem_en=%b, required 0001 0 1", state, instr_count, mem_en);
    end
  endtask

  task automatic test_add();
    bit e;
    run_instr(2'b00, 4'($urandom_range(0, 15)), 1'b0, 1'b0, 1, e);
  endtask

  task automatic test_branch();
    bit e;
    run_instr(2'b01, 4'($urandom_range(0, 7)), 1'b1, 1'($urandom_range(0, 1)), -1, e);
    run_instr(2'b01, 4'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)), -1, e);
  endtask

  task automatic test_ldi_sti();
    bit e;
    run_instr(2'b10, 4'b0001, 1'b0, 1'b0, -1, e);
    run_instr(2'b10, 4'b0000, 1'b0, 1'b1, -1, e);
    run_instr(2'b10, 4'b0010, 1'b0, 1'b0, 0, e);
    run_instr(2'b10, 4'b0100, 1'b0, 1'b0, 2, e);
    run_instr(2'b10, 4'b0110, 1'b0, 1'b0, 0, e);
  endtask

  task automatic test_jsr();
    bit e;
    run_instr(2'b01, 4'b1000 | 4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, -1, e);
  endtask

  task automatic test_random();
    bit e;
    logic [1:0] cls;
    logic [3:0] det;
    logic [3:0] ldst_det[6] = '{4'b0110, 4'b0010, 4'b0001, 4'b0100, 4'b0000, 4'b0011};
    for (int i = 0; i < 60; i++) begin
      cls = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      det = (cls == 2'b10) ? ldst_det[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
      run_instr(cls, det, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, e);
      if (e) do_reset();
    end
  endtask

  task automatic test_bad_opcode();
    bit e;
    run_instr(2'b11, 4'($urandom_range(0, 15)), 1'b0, 1'b0, -1, e);
    do_reset();
    run_instr(2'b10, 4'b0000, 1'b0, 1'b0, -1, e);
    do_reset();
  endtask

  task automatic test_reset_mid_access();
    c_control = {2'b10, 4'b0010};
    f_control = 1'b0;
    m_control = 1'b0;
    mem_rdy = 1'b1;
    @(negedge clock);
    mem_rdy = 1'b0;
    @(negedge clock);
    @(negedge clock);
    compared++;
    if (state !== S_RMEM || mem_en !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_access_setup: state=%b mem_en=%b, required 0100 1", state, mem_en);
    end
    #2 reset = 1'b0;
    #1;
    compared++;
    if (state !== S_RESET || mem_en !== 1'b0 || instr_count !== 16'd0) begin
      mismatched++;
      $display("FAIL async_reset: state=%b mem_en=%b count=%0d, required 0000 0 0", state, mem_en, instr_count);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    model_count = 0;
    compared++;
    if (state !== S_FETCH || instr_count !== 16'd0) begin
      mismatched++;
      $display("FAIL reset_release: state=%b count=%0d, required 0001 0", state, instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_ldi_sti();
    test_jsr();
    test_random();
    test_bad_opcode();
    test_add();
    test_reset_mid_access();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
